// File: rtl/pwm_multichannel.sv
// Multi-channel PWM with one shared period counter and per-channel duty compare.
// Period, duty and mode are double-buffered and switch only at a period boundary.
module pwm_multichannel #(
  parameter int NUM_CH    = 4,
  parameter int BIT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          center_mode,
  input  logic [BIT_WIDTH-1:0]          period,
  input  logic                          period_wr,
  input  logic [NUM_CH*BIT_WIDTH-1:0]   duty_in,
  input  logic [NUM_CH-1:0]             duty_wr,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic                          period_start,
  output logic                          update_pend
);

  localparam int W = BIT_WIDTH;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic         dir;
  logic         dir_nxt;
  logic         mode_act;
  logic         en_d;
  logic [W-1:0] period_shadow;
  logic [W-1:0] period_act;
  logic [W-1:0] duty_shadow [NUM_CH];
  logic [W-1:0] duty_act [NUM_CH];
  logic         bnd;
  logic         wr_any;
  logic         falling;
  logic [NUM_CH-1:0] hi;

  // dir=1 means counting down; the first enabled edge holds cnt at 0
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b0;
    if (!en_d) begin
      cnt_nxt = '0;
    end else if (!mode_act) begin
      cnt_nxt = (cnt >= period_act) ? '0 : cnt + ONE;
    end else if (!dir) begin
      if (cnt >= period_act) begin
        cnt_nxt = (cnt == '0) ? '0 : cnt - ONE;
        dir_nxt = (cnt > ONE);
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else begin
      cnt_nxt = cnt - ONE;
      dir_nxt = (cnt > ONE);
    end
  end

  assign bnd    = en & (cnt_nxt == '0);
  assign wr_any = period_wr | (|duty_wr);

  // Rising half uses cnt < duty, falling half (incl. top) uses cnt <= duty,
  // giving 2*duty high cycles around cnt=0.
  always_comb begin
    falling = mode_act & (dir | (cnt >= period_act));
    hi = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (falling)
        hi[i] = (duty_act[i] != '0) && (cnt <= duty_act[i]);
      else
        hi[i] = (cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      dir           <= 1'b0;
      mode_act      <= 1'b0;
      en_d          <= 1'b0;
      period_shadow <= '1;
      period_act    <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_act[i]    <= '0;
      end
      pwm_out       <= '0;
      period_start  <= 1'b0;
      update_pend   <= 1'b0;
    end else begin
      en_d        <= en;
      update_pend <= wr_any | (update_pend & ~bnd);
      if (bnd) begin
        period_act <= period_shadow;
        mode_act   <= center_mode;
        for (int i = 0; i < NUM_CH; i++)
          duty_act[i] <= duty_shadow[i];
      end
      if (period_wr)
        period_shadow <= period;
      for (int i = 0; i < NUM_CH; i++)
        if (duty_wr[i])
          duty_shadow[i] <= duty_in[i*W +: W];
      if (en) begin
        cnt          <= cnt_nxt;
        dir          <= dir_nxt;
        pwm_out      <= hi;
        period_start <= en_d & (cnt == '0);
      end else begin
        cnt          <= '0;
        dir          <= 1'b0;
        pwm_out      <= '0;
        period_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: edge/center modes, shadow timing,
// period change, reset and re-enable behaviour.
module tb_pwm_multichannel;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           center_mode;
  logic [W-1:0]   period;
  logic           period_wr;
  logic [N*W-1:0] duty_in;
  logic [N-1:0]   duty_wr;
  logic [N-1:0]   pwm_out;
  logic           period_start;
  logic           update_pend;

  int errors = 0;
  int checks = 0;
  int hc [N];
  int psc;
  logic [31:0] pat0;

  always #5 clk = ~clk;

  pwm_multichannel #(.NUM_CH(N), .BIT_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .center_mode(center_mode),
    .period(period),
    .period_wr(period_wr),
    .duty_in(duty_in),
    .duty_wr(duty_wr),
    .pwm_out(pwm_out),
    .period_start(period_start),
    .update_pend(update_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input int ch, input int v);
    logic [31:0] t;
    t = v;
    duty_in[ch*W +: W] = t[W-1:0];
  endtask

  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(period_start), 32'd1);
  endtask

  // Samples L cycles from the current one; optional strobe at index wr_at
  task automatic meas(input int L, input int wr_at,
                      input logic [N-1:0] dmask, input logic pwr);
    for (int c = 0; c < N; c++) hc[c] = 0;
    psc = 0;
    pat0 = '0;
    for (int i = 0; i < L; i++) begin
      for (int c = 0; c < N; c++)
        if (pwm_out[c]) hc[c]++;
      if (period_start) psc++;
      if (pwm_out[0]) pat0[i] = 1'b1;
      if (i == wr_at) begin
        duty_wr   = dmask;
        period_wr = pwr;
      end
      tick();
      duty_wr   = '0;
      period_wr = 1'b0;
      if (i == wr_at) chk("pend_after_wr", 32'(update_pend), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    center_mode = 1'b0;
    period = '0;
    period_wr = 1'b0;
    duty_in = '0;
    duty_wr = '0;
    repeat (3) tick();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_pend", 32'(update_pend), 32'd0);
    rst = 1'b0;
    tick();

    // edge mode, P=9
    period = 16'd9;
    set_duty(0, 3);
    set_duty(1, 0);
    set_duty(2, 10);
    set_duty(3, 5);
    period_wr = 1'b1;
    duty_wr = 4'hF;
    tick();
    period_wr = 1'b0;
    duty_wr = '0;
    chk("t1_pend", 32'(update_pend), 32'd1);
    en = 1'b1;
    wait_ps("t1_start");
    chk("t1_ps_out", 32'(pwm_out), 32'hD);
    meas(10, -1, '0, 1'b0);
    chk("t1_ch0", hc[0], 3);
    chk("t1_ch1", hc[1], 0);
    chk("t1_ch2", hc[2], 10);
    chk("t1_ch3", hc[3], 5);
    chk("t1_psc", psc, 1);
    chk("t1_pat0", pat0, 32'h007);
    chk("t1_next_ps", 32'(period_start), 32'd1);
    chk("t1_pend_clr", 32'(update_pend), 32'd0);

    // duty write mid-period at cnt=4
    set_duty(0, 7);
    meas(10, 3, 4'b0001, 1'b0);
    chk("t3_cur_ch0", hc[0], 3);
    chk("t3_ps", 32'(period_start), 32'd1);
    chk("t3_pend_clr", 32'(update_pend), 32'd0);
    meas(10, -1, '0, 1'b0);
    chk("t3_new_ch0", hc[0], 7);
    chk("t3_new_pat", pat0, 32'h07F);

    // duty write on the boundary edge
    set_duty(0, 2);
    meas(10, 8, 4'b0001, 1'b0);
    chk("t4_cur_ch0", hc[0], 7);
    chk("t4_pend_hold", 32'(update_pend), 32'd1);
    meas(10, -1, '0, 1'b0);
    chk("t4_skip_ch0", hc[0], 7);
    chk("t4_pend_clr", 32'(update_pend), 32'd0);
    meas(10, -1, '0, 1'b0);
    chk("t4_new_ch0", hc[0], 2);
    chk("t4_new_pat", pat0, 32'h003);

    // period 9 -> 4 written at cnt=7
    period = 16'd4;
    meas(10, 6, '0, 1'b1);
    chk("t5_old_ch0", hc[0], 2);
    chk("t5_old_psc", psc, 1);
    chk("t5_ps", 32'(period_start), 32'd1);
    meas(5, -1, '0, 1'b0);
    chk("t5_ch0", hc[0], 2);
    chk("t5_ch1", hc[1], 0);
    chk("t5_ch2", hc[2], 5);
    chk("t5_ch3", hc[3], 5);
    chk("t5_psc", psc, 1);
    chk("t5_ps_next", 32'(period_start), 32'd1);

    // center mode, P=8, duty0=2
    center_mode = 1'b1;
    period = 16'd8;
    set_duty(0, 2);
    meas(5, 1, 4'b0001, 1'b1);
    chk("t2_last_edge_ch0", hc[0], 2);
    chk("t2_ps", 32'(period_start), 32'd1);
    meas(16, -1, '0, 1'b0);
    chk("t2_ch0", hc[0], 4);
    chk("t2_pat0", pat0, 32'hC003);
    chk("t2_ch1", hc[1], 0);
    chk("t2_ch2", hc[2], 16);
    chk("t2_ch3", hc[3], 10);
    chk("t2_psc", psc, 1);
    chk("t2_ps_next", 32'(period_start), 32'd1);

    // reset mid-period with a pending write
    set_duty(0, 5);
    duty_wr = 4'b0001;
    tick();
    duty_wr = '0;
    chk("t6_pend", 32'(update_pend), 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
    chk("t6_rst_ps", 32'(period_start), 32'd0);
    chk("t6_rst_pend", 32'(update_pend), 32'd0);
    rst = 1'b0;
    en = 1'b0;
    center_mode = 1'b0;
    repeat (2) tick();
    en = 1'b1;
    tick();
    chk("t6_prime_ps", 32'(period_start), 32'd0);
    tick();
    chk("t6_fresh_ps", 32'(period_start), 32'd1);
    meas(20, -1, '0, 1'b0);
    chk("t6_lost_ch0", hc[0], 0);
    chk("t6_psc", psc, 1);

    // re-enable loads pending shadows
    period = 16'd3;
    set_duty(0, 1);
    period_wr = 1'b1;
    duty_wr = 4'b0001;
    tick();
    period_wr = 1'b0;
    duty_wr = '0;
    en = 1'b0;
    tick();
    chk("t7_en0_pwm", 32'(pwm_out), 32'd0);
    en = 1'b1;
    tick();
    chk("t7_pend_clr", 32'(update_pend), 32'd0);
    tick();
    chk("t7_ps", 32'(period_start), 32'd1);
    meas(4, -1, '0, 1'b0);
    chk("t7_pat0", pat0, 32'h1);
    chk("t7_psc", psc, 1);
    chk("t7_ps_next", 32'(period_start), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
